// File: rtl/round_robin_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant and a bounded hold time.
// A grant is dropped voluntarily when its request falls, or forcibly after MAX_HOLD cycles.
module round_robin_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hcnt;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_gnt_valid;
  logic       r_preempt;

  state_t     w_state_nx;
  logic [2:0] w_ptr_nx;
  logic [7:0] w_hcnt_nx;
  logic [7:0] w_gnt_nx;
  logic [2:0] w_gnt_id_nx;
  logic       w_gnt_valid_nx;
  logic       w_preempt_nx;

  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;

  // First set request scanning upward from the pointer, wrapping through 3-bit arithmetic.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_hcnt_nx      = r_hcnt;
    w_gnt_nx       = r_gnt;
    w_gnt_id_nx    = r_gnt_id;
    w_gnt_valid_nx = r_gnt_valid;
    w_preempt_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_state_nx     = S_GRANT;
          w_gnt_nx       = 8'd1 << w_win;
          w_gnt_id_nx    = w_win;
          w_gnt_valid_nx = 1'b1;
          w_hcnt_nx      = '0;
        end else begin
          w_gnt_nx       = '0;
          w_gnt_id_nx    = '0;
          w_gnt_valid_nx = 1'b0;
        end
      end
      S_GRANT: begin
        // Voluntary release is tested first so it wins over a simultaneous hold expiry.
        if (!req[r_gnt_id] || (r_hcnt == HOLD_LAST)) begin
          w_state_nx     = S_IDLE;
          w_gnt_nx       = '0;
          w_gnt_id_nx    = '0;
          w_gnt_valid_nx = 1'b0;
          w_hcnt_nx      = '0;
          w_ptr_nx       = r_gnt_id + 3'd1;
          w_preempt_nx   = req[r_gnt_id];
        end else begin
          w_hcnt_nx = r_hcnt + 8'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_hcnt      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_hcnt      <= w_hcnt_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_id    <= w_gnt_id_nx;
      r_gnt_valid <= w_gnt_valid_nx;
      r_preempt   <= w_preempt_nx;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_round_robin_arbiter8.sv
// Directed bench for round_robin_arbiter8 (MAX_HOLD=4): per-cycle scoreboard plus invariant monitor.
module tb_round_robin_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        run     = 1'b0;
  logic        prev_pre = 1'b0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t sb[$];

  round_robin_arbiter8 #(.MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] enc(logic [7:0] g);
    logic [2:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) if (g[i]) e = 3'(i);
    return e;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus, queue the grant expected after the next edge, then compare.
  task automatic cyc(string tag, logic [7:0] r, logic e, logic [7:0] eg, logic ep);
    exp_t x;
    req = r;
    en  = e;
    x.gnt = eg;
    x.id  = enc(eg);
    x.v   = |eg;
    x.pre = ep;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".gnt"},   gnt,                 x.gnt);
      chk({x.tag, ".id"},    {5'b0, gnt_id},      {5'b0, x.id});
      chk({x.tag, ".valid"}, {7'b0, gnt_valid},   {7'b0, x.v});
      chk({x.tag, ".pre"},   {7'b0, preempt},     {7'b0, x.pre});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        chk("inv_onehot", {7'b0, ($countones(gnt) <= 1)}, 8'd1);
        chk("inv_id",     {5'b0, gnt_id},    {5'b0, enc(gnt)});
        chk("inv_valid",  {7'b0, gnt_valid}, {7'b0, |gnt});
        chk("inv_pre_gnt",   {7'b0, preempt & (|gnt)}, 8'd0);
        chk("inv_pre_pulse", {7'b0, preempt & prev_pre}, 8'd0);
        prev_pre = preempt;
      end
    end
  end

  initial begin
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.gnt",   gnt,               8'h00);
    chk("rst.id",    {5'b0, gnt_id},    8'h00);
    chk("rst.valid", {7'b0, gnt_valid}, 8'h00);
    chk("rst.pre",   {7'b0, preempt},   8'h00);
    rst = 1'b0;

    // Two requesters at the ends of the ring; releasing owner 7 wraps the pointer to 0.
    cyc("s1_g0",   8'h81, 1'b1, 8'h01, 1'b0);
    cyc("s1_h0",   8'h81, 1'b1, 8'h01, 1'b0);
    cyc("s1_rel0", 8'h80, 1'b1, 8'h00, 1'b0);
    cyc("s1_g7",   8'h80, 1'b1, 8'h80, 1'b0);
    cyc("s1_h7",   8'h80, 1'b1, 8'h80, 1'b0);
    cyc("s1_rel7", 8'h00, 1'b1, 8'h00, 1'b0);
    cyc("s1_idle", 8'h00, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'd1 << (i % 8);
      cyc("s2_g",   8'hFF, 1'b1, oh, 1'b0);
      cyc("s2_h1",  8'hFF, 1'b1, oh, 1'b0);
      cyc("s2_h2",  8'hFF, 1'b1, oh, 1'b0);
      cyc("s2_rel", 8'hFF & ~oh, 1'b1, 8'h00, 1'b0);
    end

    cyc("s3_g",    8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h1",   8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h2",   8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h3",   8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_force",8'h04, 1'b1, 8'h00, 1'b1);
    cyc("s3_regnt",8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h1b",  8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h2b",  8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_h3b",  8'h04, 1'b1, 8'h04, 1'b0);
    cyc("s3_vol",  8'h00, 1'b1, 8'h00, 1'b0);
    cyc("s3_idle", 8'h00, 1'b1, 8'h00, 1'b0);

    cyc("s4_en0a", 8'h10, 1'b0, 8'h00, 1'b0);
    cyc("s4_en0b", 8'h10, 1'b0, 8'h00, 1'b0);
    cyc("s4_g",    8'h10, 1'b1, 8'h10, 1'b0);
    cyc("s4_h1",   8'h10, 1'b0, 8'h10, 1'b0);
    cyc("s4_h2",   8'hFF, 1'b0, 8'h10, 1'b0);
    cyc("s4_rel",  8'hEF, 1'b0, 8'h00, 1'b0);
    cyc("s4_gate", 8'hFF, 1'b0, 8'h00, 1'b0);
    cyc("s4_gate2",8'hFF, 1'b0, 8'h00, 1'b0);

    cyc("s5_g",    8'h20, 1'b1, 8'h20, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async.gnt",   gnt,               8'h00);
    chk("s5_async.id",    {5'b0, gnt_id},    8'h00);
    chk("s5_async.valid", {7'b0, gnt_valid}, 8'h00);
    chk("s5_async.pre",   {7'b0, preempt},   8'h00);
    @(posedge clk);
    #1;
    chk("s5_held.gnt", gnt, 8'h00);
    rst = 1'b0;
    cyc("s5_ptr0", 8'h06, 1'b1, 8'h02, 1'b0);
    cyc("s5_rel",  8'h00, 1'b1, 8'h00, 1'b0);

    run = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
